// File: rtl/pes_car_ps_pkg.sv
// Shared types and constants for the parking-lot controller: FSM state encoding
// and active-high 7-segment patterns (bit 6 = g ... bit 0 = a).
package pes_car_ps_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_PW  = 3'd1,
      WRONG_PW = 3'd2,
      OPEN     = 3'd3,
      LOCKOUT  = 3'd4
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/pes_seg7_dec.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes show blank.
module pes_seg7_dec
   import pes_car_ps_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/pes_car_ps_ctrl.sv
// Parking-lot gate controller: occupancy tracking, entry code with retry limit,
// lockout and timeout, plus a registered two-digit occupancy display.
module pes_car_ps_ctrl
   import pes_car_ps_pkg::*;
#(
   parameter int                    PW_WIDTH    = 4,
   parameter logic [PW_WIDTH-1:0]   PASSWORD    = 'hA,
   parameter int                    MAX_SLOTS   = 15,
   parameter int                    CNT_W       = 7,
   parameter int                    WAIT_CYCLES = 32,
   parameter int                    MAX_TRIES   = 3,
   parameter int                    LOCK_CYCLES = 64
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                sensor_entrance,
   input  logic                sensor_exit,
   input  logic                sensor_depart,
   input  logic                pw_valid,
   input  logic [PW_WIDTH-1:0] pw_in,
   output logic                green_led,
   output logic                red_led,
   output logic                full,
   output logic [CNT_W-1:0]    occupancy,
   output logic [6:0]          hex_1,
   output logic [6:0]          hex_2,
   output state_t              dbg_state
);

   localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int TRY_W   = $clog2(MAX_TRIES + 1);

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   timer;
   logic [TRY_W-1:0]   tries, tries_nxt, tries_inc;
   logic               exit_q, depart_q;
   logic               exit_rise, depart_rise;
   logic               tmr_clr, timed, entry_done, dec_ok;
   logic [CNT_W-1:0]   occ_nxt;
   logic [3:0]         tens_dig, units_dig;
   logic [6:0]         seg_tens, seg_units;

   assign exit_rise   = sensor_exit & ~exit_q;
   assign depart_rise = sensor_depart & ~depart_q;
   assign tries_inc   = tries + TRY_W'(1);
   assign timed       = (state == WAIT_PW) || (state == WRONG_PW) || (state == LOCKOUT);

   // pw_valid is a one-cycle strobe with no back-pressure: a code is consumed
   // on the cycle it is presented, and only WAIT_PW/WRONG_PW look at it.
   always_comb begin
      state_nxt  = state;
      tries_nxt  = tries;
      tmr_clr    = 1'b0;
      entry_done = 1'b0;
      case (state)
         IDLE: begin
            if (sensor_entrance && !full) begin
               state_nxt = WAIT_PW;
               tries_nxt = '0;
            end
         end
         WAIT_PW, WRONG_PW: begin
            if (pw_valid) begin
               tmr_clr = 1'b1;
               if (pw_in == PASSWORD) begin
                  state_nxt = OPEN;
               end else begin
                  tries_nxt = tries_inc;
                  state_nxt = (tries_inc == TRY_W'(MAX_TRIES)) ? LOCKOUT : WRONG_PW;
               end
            end else if (timer == TMR_W'(WAIT_CYCLES - 1)) begin
               state_nxt = IDLE;
            end
         end
         OPEN: begin
            if (exit_rise) begin
               entry_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         LOCKOUT: begin
            if (timer == TMR_W'(LOCK_CYCLES - 1)) begin
               state_nxt = IDLE;
               tries_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) tmr_clr = 1'b1;
   end

   // Simultaneous entry and departure cancel; a departure at zero is dropped.
   always_comb begin
      dec_ok  = depart_rise && (occupancy != '0);
      occ_nxt = occupancy;
      if (entry_done && !dec_ok)
         occ_nxt = occupancy + CNT_W'(1);
      else if (!entry_done && dec_ok)
         occ_nxt = occupancy - CNT_W'(1);
   end

   assign tens_dig  = 4'(occ_nxt / CNT_W'(10));
   assign units_dig = 4'(occ_nxt % CNT_W'(10));

   pes_seg7_dec u_seg_tens (
      .digit (tens_dig),
      .seg   (seg_tens)
   );

   pes_seg7_dec u_seg_units (
      .digit (units_dig),
      .seg   (seg_units)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         tries     <= '0;
         exit_q    <= 1'b0;
         depart_q  <= 1'b0;
         occupancy <= '0;
         full      <= 1'b0;
         hex_1     <= SEG_0;
         hex_2     <= SEG_0;
      end else begin
         state     <= state_nxt;
         tries     <= tries_nxt;
         timer     <= (tmr_clr || !timed) ? '0 : timer + TMR_W'(1);
         exit_q    <= sensor_exit;
         depart_q  <= sensor_depart;
         occupancy <= occ_nxt;
         full      <= (occ_nxt == CNT_W'(MAX_SLOTS));
         hex_1     <= seg_tens;
         hex_2     <= seg_units;
      end
   end

   // Red blinks in WRONG_PW off the timer LSB, which restarts on every new attempt.
   assign green_led = (state == OPEN);
   assign red_led   = (state == WAIT_PW) || (state == LOCKOUT) ||
                      ((state == WRONG_PW) && !timer[0]);
   assign dbg_state = state;

endmodule

// File: tb/tb_pes_car_ps_ctrl.sv
// Directed bench for pes_car_ps_ctrl: a vector table for single-cycle behaviour
// plus hand-written sequences for lockout, timeout, full lot and reset.
module tb_pes_car_ps_ctrl;
   import pes_car_ps_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sensor_entrance = 1'b0;
   logic       sensor_exit = 1'b0;
   logic       sensor_depart = 1'b0;
   logic       pw_valid = 1'b0;
   logic [3:0] pw_in = 4'h0;
   logic       green_led, red_led, full;
   logic [6:0] occupancy;
   logic [6:0] hex_1, hex_2;
   state_t     dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_occ  = 0;

   typedef struct {
      logic       ent, ext, dep, pv;
      logic [3:0] pw;
      state_t     st;
      logic       g, r;
      int         occ;
   } vec_t;

   vec_t vecs[17];

   pes_car_ps_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .sensor_entrance (sensor_entrance),
      .sensor_exit     (sensor_exit),
      .sensor_depart   (sensor_depart),
      .pw_valid        (pw_valid),
      .pw_in           (pw_in),
      .green_led       (green_led),
      .red_led         (red_led),
      .full            (full),
      .occupancy       (occupancy),
      .hex_1           (hex_1),
      .hex_2           (hex_2),
      .dbg_state       (dbg_state)
   );

   always #5 clk = ~clk;

   // Bench-side segment table, g..a active-high.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic vec_t mk(input logic ent, ext, dep, pv, input logic [3:0] pw,
                               input state_t st, input logic g, r, input int occ);
      vec_t v;
      v.ent = ent; v.ext = ext; v.dep = dep; v.pv = pv; v.pw = pw;
      v.st = st; v.g = g; v.r = r; v.occ = occ;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_all(input string name, input state_t st, input logic g, input logic r,
                            input int occ);
      chk({name, ".state"}, int'(dbg_state), int'(st));
      chk({name, ".green"}, int'(green_led), int'(g));
      chk({name, ".red"}, int'(red_led), int'(r));
      chk({name, ".occ"}, int'(occupancy), occ);
      chk({name, ".full"}, int'(full), (occ == 15) ? 1 : 0);
      chk({name, ".hex_1"}, int'(hex_1), int'(seg_of(occ / 10)));
      chk({name, ".hex_2"}, int'(hex_2), int'(seg_of(occ % 10)));
   endtask

   task automatic set_in(input logic ent, ext, dep, pv, input logic [3:0] pw);
      sensor_entrance = ent;
      sensor_exit     = ext;
      sensor_depart   = dep;
      pw_valid        = pv;
      pw_in           = pw;
   endtask

   // Complete one good entry starting from IDLE; occupancy expected to rise by one.
   task automatic do_entry(input string name);
      set_in(1, 0, 0, 0, 4'h0); tick();
      set_in(0, 0, 0, 1, 4'hA); tick();
      check_all({name, ".open"}, OPEN, 1'b1, 1'b0, exp_occ);
      set_in(0, 1, 0, 0, 4'h0); tick();
      exp_occ++;
      check_all({name, ".done"}, IDLE, 1'b0, 1'b0, exp_occ);
      set_in(0, 0, 0, 0, 4'h0); tick();
   endtask

   task automatic do_depart(input string name);
      set_in(0, 0, 1, 0, 4'h0); tick();
      if (exp_occ > 0) exp_occ--;
      check_all(name, IDLE, 1'b0, 1'b0, exp_occ);
      set_in(0, 0, 0, 0, 4'h0); tick();
   endtask

   initial begin
      //               ent ext dep pv  pw     state     g  r  occ
      vecs[0]  = mk(1, 0, 0, 0, 4'h0, WAIT_PW,  0, 1, 0);
      vecs[1]  = mk(1, 0, 0, 1, 4'hA, OPEN,     1, 0, 0);
      vecs[2]  = mk(0, 1, 0, 0, 4'h0, IDLE,     0, 0, 1);
      vecs[3]  = mk(0, 0, 0, 0, 4'h0, IDLE,     0, 0, 1);
      vecs[4]  = mk(0, 0, 1, 0, 4'h0, IDLE,     0, 0, 0);
      vecs[5]  = mk(0, 0, 1, 0, 4'h0, IDLE,     0, 0, 0);
      vecs[6]  = mk(0, 0, 0, 0, 4'h0, IDLE,     0, 0, 0);
      vecs[7]  = mk(0, 0, 1, 0, 4'h0, IDLE,     0, 0, 0);
      vecs[8]  = mk(0, 0, 0, 1, 4'hA, IDLE,     0, 0, 0);
      vecs[9]  = mk(1, 0, 0, 0, 4'h0, WAIT_PW,  0, 1, 0);
      vecs[10] = mk(0, 0, 0, 1, 4'h3, WRONG_PW, 0, 1, 0);
      vecs[11] = mk(0, 0, 0, 0, 4'h0, WRONG_PW, 0, 0, 0);
      vecs[12] = mk(0, 0, 0, 0, 4'h0, WRONG_PW, 0, 1, 0);
      vecs[13] = mk(0, 0, 0, 1, 4'hB, WRONG_PW, 0, 1, 0);
      vecs[14] = mk(0, 0, 0, 1, 4'hA, OPEN,     1, 0, 0);
      vecs[15] = mk(0, 1, 0, 0, 4'h0, IDLE,     0, 0, 1);
      vecs[16] = mk(0, 0, 0, 0, 4'h0, IDLE,     0, 0, 1);

      // Reset held for five cycles
      reset = 1'b1;
      repeat (5) tick();
      reset = 1'b0;
      check_all("reset", IDLE, 1'b0, 1'b0, 0);

      for (int i = 0; i < 17; i++) begin
         set_in(vecs[i].ent, vecs[i].ext, vecs[i].dep, vecs[i].pv, vecs[i].pw);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].g, vecs[i].r, vecs[i].occ);
      end
      exp_occ = 1;

      // Three wrong codes lead to lockout; codes ignored while locked
      set_in(1, 0, 0, 0, 4'h0); tick();
      check_all("lk.wait", WAIT_PW, 1'b0, 1'b1, exp_occ);
      set_in(0, 0, 0, 1, 4'h3); tick();
      check_all("lk.wrong1", WRONG_PW, 1'b0, 1'b1, exp_occ);
      set_in(0, 0, 0, 0, 4'h0); tick();
      check_all("lk.blink1", WRONG_PW, 1'b0, 1'b0, exp_occ);
      set_in(0, 0, 0, 1, 4'h3); tick();
      check_all("lk.wrong2", WRONG_PW, 1'b0, 1'b1, exp_occ);
      set_in(0, 0, 0, 0, 4'h0); tick();
      check_all("lk.blink2", WRONG_PW, 1'b0, 1'b0, exp_occ);
      set_in(0, 0, 0, 1, 4'h3); tick();
      check_all("lk.enter", LOCKOUT, 1'b0, 1'b1, exp_occ);
      for (int i = 1; i < 64; i++) begin
         set_in(0, 0, 0, 1, 4'hA); tick();
         check_all($sformatf("lk.hold%0d", i), LOCKOUT, 1'b0, 1'b1, exp_occ);
      end
      set_in(0, 0, 0, 0, 4'h0); tick();
      check_all("lk.release", IDLE, 1'b0, 1'b0, exp_occ);
      do_entry("lk.after");

      // Code-entry timeout
      set_in(1, 0, 0, 0, 4'h0); tick();
      set_in(0, 0, 0, 0, 4'h0);
      for (int i = 1; i < 32; i++) begin
         tick();
         check_all($sformatf("to.wait%0d", i), WAIT_PW, 1'b0, 1'b1, exp_occ);
      end
      tick();
      check_all("to.idle", IDLE, 1'b0, 1'b0, exp_occ);

      // Fill the lot, entrance refused, then one departure
      while (exp_occ < 15) do_entry($sformatf("fill%0d", exp_occ));
      chk("full.flag", int'(full), 1);
      chk("full.hex_1", int'(hex_1), 7'h06);
      chk("full.hex_2", int'(hex_2), 7'h6D);
      set_in(1, 0, 0, 0, 4'h0); tick();
      check_all("full.refuse1", IDLE, 1'b0, 1'b0, exp_occ);
      tick();
      check_all("full.refuse2", IDLE, 1'b0, 1'b0, exp_occ);
      set_in(0, 0, 0, 0, 4'h0); tick();
      do_depart("full.depart");
      chk("full.after", int'(occupancy), 14);

      // Simultaneous entry completion and departure at 7
      while (exp_occ > 7) do_depart($sformatf("drain%0d", exp_occ));
      set_in(1, 0, 0, 0, 4'h0); tick();
      set_in(0, 0, 0, 1, 4'hA); tick();
      check_all("same.open", OPEN, 1'b1, 1'b0, 7);
      set_in(0, 1, 1, 0, 4'h0); tick();
      check_all("same.cycle", IDLE, 1'b0, 1'b0, 7);
      set_in(0, 0, 0, 0, 4'h0); tick();

      // Reset while the gate is open
      set_in(1, 0, 0, 0, 4'h0); tick();
      set_in(0, 0, 0, 1, 4'hA); tick();
      check_all("rst.open", OPEN, 1'b1, 1'b0, 7);
      set_in(0, 0, 0, 0, 4'h0);
      reset = 1'b1; tick();
      reset = 1'b0;
      exp_occ = 0;
      check_all("rst.abort", IDLE, 1'b0, 1'b0, 0);

      // Departure at zero is ignored
      do_depart("zero.depart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
